// File: rtl/ball_motion_ctrl.sv
// Keyboard-driven ball motion stage: decodes WASD into a signed per-frame step with
// hold-to-accelerate, and resolves wall bounces one frame ahead of the position register.
module ball_motion_ctrl #(
   parameter int          STEP_MIN    = 1,
   parameter int          STEP_MAX    = 4,
   parameter int          HOLD_FRAMES = 8,
   parameter int          X_MIN       = 0,
   parameter int          X_MAX       = 639,
   parameter int          Y_MIN       = 0,
   parameter int          Y_MAX       = 479,
   parameter logic [7:0]  KEY_W       = 8'h1A,
   parameter logic [7:0]  KEY_A       = 8'h04,
   parameter logic [7:0]  KEY_S       = 8'h16,
   parameter logic [7:0]  KEY_D       = 8'h07
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic [7:0]  keycode,
   input  logic [9:0]  Ball_X,
   input  logic [9:0]  Ball_Y,
   input  logic [9:0]  Ball_S,
   output logic [9:0]  Motion_X,
   output logic [9:0]  Motion_Y,
   output logic        Motion_valid,
   output logic [2:0]  Dir
);

   localparam int HW = $clog2(HOLD_FRAMES + 1);

   typedef enum logic [2:0] {
      ST_STOP  = 3'd0,
      ST_UP    = 3'd1,
      ST_DOWN  = 3'd2,
      ST_LEFT  = 3'd3,
      ST_RIGHT = 3'd4
   } dir_t;

   dir_t          r_dir, w_nxt_dir, w_cmd;
   logic [9:0]    r_speed, w_nxt_speed;
   logic [HW-1:0] r_hold, w_nxt_hold;
   logic [9:0]    r_motion_x, r_motion_y, w_nxt_x, w_nxt_y;
   logic          r_valid, r_fc_q;
   logic          w_tick, w_cmd_vld;
   logic [10:0]   w_bx, w_by, w_bs, w_sp;

   // Rising-edge detect on the frame level gives exactly one tick per frame.
   assign w_tick = frame_clk & ~r_fc_q;

   always_comb begin
      w_cmd     = ST_STOP;
      w_cmd_vld = 1'b0;
      case (keycode)
         KEY_W:   begin w_cmd = ST_UP;    w_cmd_vld = 1'b1; end
         KEY_S:   begin w_cmd = ST_DOWN;  w_cmd_vld = 1'b1; end
         KEY_A:   begin w_cmd = ST_LEFT;  w_cmd_vld = 1'b1; end
         KEY_D:   begin w_cmd = ST_RIGHT; w_cmd_vld = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      w_nxt_dir   = r_dir;
      w_nxt_speed = r_speed;
      w_nxt_hold  = '0;
      w_nxt_x     = 10'd0;
      w_nxt_y     = 10'd0;
      w_bx        = {1'b0, Ball_X};
      w_by        = {1'b0, Ball_Y};
      w_bs        = {1'b0, Ball_S};

      if (w_cmd_vld) begin
         if (w_cmd == r_dir) begin
            if (r_hold == HW'(HOLD_FRAMES - 1)) begin
               w_nxt_hold = '0;
               if (r_speed < 10'(STEP_MAX))
                  w_nxt_speed = r_speed + 10'd1;
            end else begin
               w_nxt_hold = r_hold + HW'(1);
            end
         end else begin
            w_nxt_dir   = w_cmd;
            w_nxt_speed = 10'(STEP_MIN);
            w_nxt_hold  = '0;
         end
      end

      // Bounce uses the post-key direction and speed so the step is already wall-safe.
      w_sp = {1'b0, w_nxt_speed};
      case (w_nxt_dir)
         ST_UP:    if (w_by <= 11'(Y_MIN) + w_bs + w_sp)        begin w_nxt_dir = ST_DOWN;  w_nxt_hold = '0; end
         ST_DOWN:  if (w_by + w_bs + w_sp >= 11'(Y_MAX))        begin w_nxt_dir = ST_UP;    w_nxt_hold = '0; end
         ST_LEFT:  if (w_bx <= 11'(X_MIN) + w_bs + w_sp)        begin w_nxt_dir = ST_RIGHT; w_nxt_hold = '0; end
         ST_RIGHT: if (w_bx + w_bs + w_sp >= 11'(X_MAX))        begin w_nxt_dir = ST_LEFT;  w_nxt_hold = '0; end
         default:  ;
      endcase

      case (w_nxt_dir)
         ST_UP:    w_nxt_y = 10'd0 - w_nxt_speed;
         ST_DOWN:  w_nxt_y = w_nxt_speed;
         ST_LEFT:  w_nxt_x = 10'd0 - w_nxt_speed;
         ST_RIGHT: w_nxt_x = w_nxt_speed;
         default:  ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_fc_q     <= 1'b0;
         r_valid    <= 1'b0;
         r_dir      <= ST_STOP;
         r_speed    <= 10'(STEP_MIN);
         r_hold     <= '0;
         r_motion_x <= 10'd0;
         r_motion_y <= 10'd0;
      end else begin
         r_fc_q  <= frame_clk;
         r_valid <= w_tick;
         if (w_tick) begin
            r_dir      <= w_nxt_dir;
            r_speed    <= w_nxt_speed;
            r_hold     <= w_nxt_hold;
            r_motion_x <= w_nxt_x;
            r_motion_y <= w_nxt_y;
         end
      end
   end

   assign Motion_X     = r_motion_x;
   assign Motion_Y     = r_motion_y;
   assign Motion_valid = r_valid;
   assign Dir          = r_dir;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: acceleration, release/reverse, bounces,
// tick qualification and asynchronous reset.
module tb_ball_motion_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic [9:0] Ball_X = 10'd320;
   logic [9:0] Ball_Y = 10'd240;
   logic [9:0] Ball_S = 10'd4;
   logic [9:0] Motion_X, Motion_Y;
   logic       Motion_valid;
   logic [2:0] Dir;

   int n_checks = 0;
   int n_fail   = 0;
   int valid_cnt = 0;

   ball_motion_ctrl dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .frame_clk    (frame_clk),
      .keycode      (keycode),
      .Ball_X       (Ball_X),
      .Ball_Y       (Ball_Y),
      .Ball_S       (Ball_S),
      .Motion_X     (Motion_X),
      .Motion_Y     (Motion_Y),
      .Motion_valid (Motion_valid),
      .Dir          (Dir)
   );

   always #10 Clk = ~Clk;

   // Counts Clk cycles during which Motion_valid was high.
   always @(posedge Clk) if (Motion_valid === 1'b1) valid_cnt++;

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
      Ball_X = 10'd320; Ball_Y = 10'd240; Ball_S = 10'd4;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   // Raise frame_clk for hi_cycles, then one low cycle; returns at a negedge with outputs settled.
   task automatic do_tick(input int hi_cycles);
      frame_clk = 1'b1;
      repeat (hi_cycles) @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_reset();
      int v0;
      @(negedge Clk);
      Reset_n = 1'b0;
      v0 = valid_cnt;
      for (int i = 0; i < 6; i++) begin
         frame_clk = ~frame_clk;
         keycode = 8'h07;
         @(negedge Clk);
      end
      n_checks++; if (Motion_X !== 10'd0) begin n_fail++; $display("FAIL reset_mx got=%h exp=000", Motion_X); end
      n_checks++; if (Motion_Y !== 10'd0) begin n_fail++; $display("FAIL reset_my got=%h exp=000", Motion_Y); end
      n_checks++; if (Dir !== 3'd0) begin n_fail++; $display("FAIL reset_dir got=%0d exp=0", Dir); end
      n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL reset_valid got=%0d pulses exp=0", valid_cnt - v0); end
      frame_clk = 1'b0; keycode = 8'h00;
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_hold_right();
      int v0;
      do_reset();
      keycode = 8'h07;
      v0 = valid_cnt;
      do_tick(1);
      n_checks++; if (Motion_X !== 10'd1) begin n_fail++; $display("FAIL acc_t1_mx got=%h exp=001", Motion_X); end
      n_checks++; if (Dir !== 3'd4) begin n_fail++; $display("FAIL acc_t1_dir got=%0d exp=4", Dir); end
      n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL acc_t1_valid got=%0d pulses exp=1", valid_cnt - v0); end
      n_checks++; if (Motion_Y !== 10'd0) begin n_fail++; $display("FAIL acc_t1_my got=%h exp=000", Motion_Y); end
      for (int t = 2; t <= 40; t++) begin
         do_tick(1);
         if (t == 8 || t == 9 || t == 24 || t >= 25) begin
            logic [9:0] exp_x;
            exp_x = (t < 9) ? 10'd1 : (t < 17) ? 10'd2 : (t < 25) ? 10'd3 : 10'd4;
            n_checks++;
            if (Motion_X !== exp_x) begin n_fail++; $display("FAIL acc_t%0d_mx got=%h exp=%h", t, Motion_X, exp_x); end
         end
      end
   endtask

   task automatic test_release_reverse();
      do_reset();
      keycode = 8'h07;
      repeat (17) do_tick(1);
      n_checks++; if (Motion_X !== 10'd3) begin n_fail++; $display("FAIL rr_start_mx got=%h exp=003", Motion_X); end
      keycode = 8'h00;
      for (int i = 0; i < 3; i++) begin
         do_tick(1);
         n_checks++; if (Motion_X !== 10'd3) begin n_fail++; $display("FAIL rr_release%0d_mx got=%h exp=003", i, Motion_X); end
      end
      keycode = 8'h04;
      do_tick(1);
      n_checks++; if (Motion_X !== 10'h3FF) begin n_fail++; $display("FAIL rr_rev_mx got=%h exp=3ff", Motion_X); end
      n_checks++; if (Dir !== 3'd3) begin n_fail++; $display("FAIL rr_rev_dir got=%0d exp=3", Dir); end
   endtask

   task automatic test_bottom_bounce();
      do_reset();
      keycode = 8'h16;
      do_tick(1);
      Ball_Y = 10'd474;
      do_tick(1);
      n_checks++; if (Dir !== 3'd1) begin n_fail++; $display("FAIL bb_dir got=%0d exp=1", Dir); end
      n_checks++; if (Motion_Y !== 10'h3FF) begin n_fail++; $display("FAIL bb_my got=%h exp=3ff", Motion_Y); end
      // Cleared hold: seven same-direction ticks stay at speed 1, the eighth accelerates.
      Ball_Y = 10'd240; keycode = 8'h1A;
      repeat (7) do_tick(1);
      n_checks++; if (Motion_Y !== 10'h3FF) begin n_fail++; $display("FAIL bb_hold7_my got=%h exp=3ff", Motion_Y); end
      do_tick(1);
      n_checks++; if (Motion_Y !== 10'h3FE) begin n_fail++; $display("FAIL bb_hold8_my got=%h exp=3fe", Motion_Y); end

      do_reset();
      keycode = 8'h16;
      do_tick(1);
      Ball_Y = 10'd473;
      do_tick(1);
      n_checks++; if (Dir !== 3'd2) begin n_fail++; $display("FAIL nb_dir got=%0d exp=2", Dir); end
      n_checks++; if (Motion_Y !== 10'd1) begin n_fail++; $display("FAIL nb_my got=%h exp=001", Motion_Y); end
   endtask

   task automatic test_left_bounce();
      do_reset();
      Ball_X = 10'd5;
      keycode = 8'h04;
      do_tick(1);
      n_checks++; if (Dir !== 3'd4) begin n_fail++; $display("FAIL lb_dir got=%0d exp=4", Dir); end
      n_checks++; if (Motion_X !== 10'd1) begin n_fail++; $display("FAIL lb_mx got=%h exp=001", Motion_X); end
   endtask

   task automatic test_tick_qual();
      int v0;
      do_reset();
      keycode = 8'h07;
      do_tick(1);
      v0 = valid_cnt;
      do_tick(10);
      n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL tq_long_valid got=%0d pulses exp=1", valid_cnt - v0); end
      v0 = valid_cnt;
      keycode = 8'h1A; @(negedge Clk);
      keycode = 8'h16; @(negedge Clk);
      keycode = 8'h1A; @(negedge Clk);
      n_checks++; if (Dir !== 3'd4) begin n_fail++; $display("FAIL tq_between_dir got=%0d exp=4", Dir); end
      n_checks++; if (Motion_X !== 10'd1 || Motion_Y !== 10'd0) begin n_fail++; $display("FAIL tq_between_m got=%h/%h exp=001/000", Motion_X, Motion_Y); end
      n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL tq_between_valid got=%0d pulses exp=0", valid_cnt - v0); end
      keycode = 8'h29;
      do_tick(1);
      n_checks++; if (Dir !== 3'd4 || Motion_X !== 10'd1) begin n_fail++; $display("FAIL tq_unknown got=dir%0d x=%h exp=dir4 x=001", Dir, Motion_X); end
      n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL tq_unknown_valid got=%0d pulses exp=1", valid_cnt - v0); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      keycode = 8'h07;
      repeat (24) do_tick(1);
      frame_clk = 1'b1;
      @(negedge Clk);
      n_checks++; if (Motion_X !== 10'd4 || Motion_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pre got=x%h v%b exp=x004 v1", Motion_X, Motion_valid); end
      #2 Reset_n = 1'b0;
      #1;
      n_checks++; if (Motion_X !== 10'd0 || Dir !== 3'd0 || Motion_valid !== 1'b0) begin n_fail++; $display("FAIL mr_abort got=x%h d%0d v%b exp=x000 d0 v0", Motion_X, Dir, Motion_valid); end
      @(negedge Clk);
      Reset_n = 1'b1; frame_clk = 1'b0;
      @(negedge Clk);
      do_tick(1);
      n_checks++; if (Motion_X !== 10'd1 || Dir !== 3'd4) begin n_fail++; $display("FAIL mr_restart got=x%h d%0d exp=x001 d4", Motion_X, Dir); end
   endtask

   initial begin
      test_reset();
      test_hold_right();
      test_release_reverse();
      test_bottom_bounce();
      test_left_bounce();
      test_tick_qual();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Upstream stage of the ball position register.
- Decodes the USB keyboard keycode into per-frame signed X/Y motion steps, with hold-to-accelerate.
- Resolves wall bounces one frame ahead, so the position stage always adds a motion value that is already correct for the frame it applies to.
- Runs on the system clock and samples the VGA frame clock as a data signal.

Parameters:
- STEP_MIN, 1: initial speed after a new direction command.
- STEP_MAX, 4: speed ceiling.
- HOLD_FRAMES, 8: consecutive same-direction frames needed per speed increment.
- X_MIN, 0 / X_MAX, 639: horizontal playfield bounds.
- Y_MIN, 0 / Y_MAX, 479: vertical playfield bounds.
- KEY_W, 8'h1A / KEY_A, 8'h04 / KEY_S, 8'h16 / KEY_D, 8'h07: HID usage codes.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA vertical-sync-rate level, synchronous to Clk.
- keycode  in  8  current HID keycode; 0x00 means no key.
- Ball_X  in  10  current ball centre X, unsigned.
- Ball_Y  in  10  current ball centre Y, unsigned.
- Ball_S  in  10  ball radius, unsigned.
- Motion_X  out  10  two's-complement X step, held between frames.
- Motion_Y  out  10  two's-complement Y step, held between frames.
- Motion_valid  out  1  one-Clk pulse on the cycle Motion_* take new values.
- Dir  out  3  state: 0 STOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT.

Behaviour:
- Reset_n low (async): Dir=STOP, speed=STEP_MIN, hold_cnt=0, Motion_X=Motion_Y=0, Motion_valid=0, fc_q=0.
- Frame tick: fc_q <= frame_clk every Clk; tick = frame_clk & ~fc_q.
  - Exactly one tick per frame_clk rising edge, regardless of how long frame_clk stays high.
- All state, speed and motion registers update only on the Clk edge where tick=1. Motion_valid is registered high on that edge and cleared on the next.
- Key decode (sampled at the tick):
  - KEY_W→UP, KEY_S→DOWN, KEY_A→LEFT, KEY_D→RIGHT.
  - 0x00 or any other code → no command.
- Direction/speed update:
  - Command equals Dir: if hold_cnt==HOLD_FRAMES-1, clear hold_cnt and increment speed (saturating at STEP_MAX). Otherwise hold_cnt++.
  - Command differs from Dir: Dir=command, speed=STEP_MIN, hold_cnt=0.
  - No command: Dir and speed hold, hold_cnt=0. The ball keeps moving after key release.
- Bounce check, applied after the key update on the same tick. Uses the new Dir and speed sp, and 11-bit unsigned arithmetic (no wrap):
  - UP and Ball_Y <= Y_MIN+Ball_S+sp → DOWN.
  - DOWN and Ball_Y+Ball_S+sp >= Y_MAX → UP.
  - LEFT and Ball_X <= X_MIN+Ball_S+sp → RIGHT.
  - RIGHT and Ball_X+Ball_S+sp >= X_MAX → LEFT.
  - A bounce keeps speed and clears hold_cnt.
  - A bounce overrides a key pressing into the wall.
- Motion encoding (sp zero-extended to 10 bits; negation is 10-bit two's complement):
  - UP: X=0, Y=-sp. DOWN: X=0, Y=+sp. LEFT: X=-sp, Y=0. RIGHT: X=+sp, Y=0. STOP: X=0, Y=0.
- Latency: Motion_* reflect the keycode and ball position sampled in the tick cycle, visible one Clk later. The downstream position stage consumes them on its next frame_clk edge.
- keycode changes between ticks have no effect.
- Reset asserted mid-frame or mid-pulse aborts immediately to reset values. The first tick after release behaves as from STOP.

Test Plan:
- Reset: Reset_n=0 with frame_clk toggling → Motion_X=Motion_Y=0, Dir=0, Motion_valid never high.
- Hold KEY_D with ball (320,240), S=4:
  - Tick 1 → Motion_X=1, Dir=4, single-cycle Motion_valid.
  - After tick 9 → Motion_X=2.
  - After tick 25 → Motion_X=4; stays 4 through tick 40.
- Release then reverse, starting at speed 3 RIGHT:
  - keycode=0x00 for 3 ticks → Motion_X stays 3.
  - Then KEY_A → next tick Motion_X=0x3FF (-1), Dir=3.
- Bottom bounce: Dir DOWN, speed 1, Ball_Y=474, S=4, KEY_S held → 474+4+1=479 → Dir=1, Motion_Y=0x3FF, hold_cnt=0.
  - Repeat with Ball_Y=473 → no bounce, Motion_Y=1.
- Tick qualification:
  - frame_clk held high 10 Clk → exactly one Motion_valid.
  - keycode 0x1A→0x16→0x1A between ticks → outputs unchanged until next tick.
  - Unknown code 0x29 → Dir and Motion hold.
- Mid-operation reset: pulse Reset_n low for 1 Clk at speed 4 RIGHT → immediate Motion_X=0, Dir=0. Next tick with KEY_D → Motion_X=1.
